// File: rtl/hi_tx_pkg.sv
//==============================================================================
// Module      : hi_tx_pkg
// Description : Shared mode and state encodings for the HF reader-transmit path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package hi_tx_pkg;

    localparam logic [1:0] MODE_OOK     = 2'b00;
    localparam logic [1:0] MODE_SHALLOW = 2'b01;
    localparam logic [1:0] MODE_CARRIER = 2'b10;
    localparam logic [1:0] MODE_OFF     = 2'b11;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_RAMP   = 2'd1,
        ST_ACTIVE = 2'd2
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/ssp_clkgen.sv
//==============================================================================
// Module      : ssp_clkgen
// Description : SSP bit clock, frame sync and bit/frame strobes from the carrier.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ssp_clkgen #(
    parameter int SSP_DIV_LOG2 = 7,
    parameter int FRAME_BITS   = 8
) (
    input  logic clk,
    input  logic rst,
    output logic o_ssp_clk,
    output logic o_ssp_frame,
    output logic o_bit_stb,
    output logic o_frame_stb
);

    localparam int                      C_FW         = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [SSP_DIV_LOG2-1:0] C_DIV_MAX    = '1;
    localparam logic [SSP_DIV_LOG2-1:0] C_DIV_STB    = C_DIV_MAX >> 1;
    localparam logic [C_FW-1:0]         C_FRAME_LAST = C_FW'(FRAME_BITS - 1);

    logic [SSP_DIV_LOG2-1:0] r_div;
    logic [C_FW-1:0]         r_fcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_fcnt <= '0;
        end else begin
            r_div <= r_div + SSP_DIV_LOG2'(1);
            if (r_div == C_DIV_MAX) begin
                r_fcnt <= (r_fcnt == C_FRAME_LAST) ? '0 : r_fcnt + C_FW'(1);
            end
        end
    end

    // Strobe fires in the last low cycle, so loads land on the ssp_clk rising edge.
    assign o_ssp_clk   = r_div[SSP_DIV_LOG2-1];
    assign o_ssp_frame = (r_fcnt == '0);
    assign o_bit_stb   = (r_div == C_DIV_STB);
    assign o_frame_stb = o_bit_stb & o_ssp_frame;

endmodule

`default_nettype wire

// File: rtl/hi_reader_tx_param.sv
//==============================================================================
// Module      : hi_reader_tx_param
// Description : HF reader transmit with field ramp, frame-aligned mode latch
//               and pause-length limiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hi_reader_tx_param
    import hi_tx_pkg::*;
#(
    parameter int SSP_DIV_LOG2   = 7,
    parameter int FRAME_BITS     = 8,
    parameter int RAMP_BITS      = 16,
    parameter int MAX_PAUSE_BITS = 4
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic       ck_1356megb,
    input  logic       field_en,
    input  logic [1:0] mod_mode,
    input  logic       ssp_dout,
    output logic       ssp_clk,
    output logic       ssp_frame,
    output logic       ssp_din,
    output logic       pwr_hi,
    output logic       pwr_lo,
    output logic       pwr_oe1,
    output logic       pwr_oe2,
    output logic       pwr_oe3,
    output logic       pwr_oe4,
    output logic       dbg
);

    localparam int               C_RW        = $clog2(RAMP_BITS + 1);
    localparam int               C_PW        = $clog2(MAX_PAUSE_BITS + 1);
    localparam logic [C_RW-1:0]  C_RAMP_LAST = C_RW'(RAMP_BITS - 1);
    localparam logic [C_PW-1:0]  C_PAUSE_MAX = C_PW'(MAX_PAUSE_BITS);

    logic w_bit_stb;
    logic w_frame_stb;
    logic w_carrier_on;

    tx_state_t       r_state;
    logic [1:0]      r_mode_q;
    logic            r_mod_bit;
    logic            r_din;
    logic [C_RW-1:0] r_rcnt;
    logic [C_PW-1:0] r_pcnt;

    ssp_clkgen #(
        .SSP_DIV_LOG2 (SSP_DIV_LOG2),
        .FRAME_BITS   (FRAME_BITS)
    ) u_clkgen (
        .clk         (ck_1356meg),
        .rst         (reset),
        .o_ssp_clk   (ssp_clk),
        .o_ssp_frame (ssp_frame),
        .o_bit_stb   (w_bit_stb),
        .o_frame_stb (w_frame_stb)
    );

    always_ff @(posedge ck_1356meg) begin
        if (reset) begin
            r_state   <= ST_OFF;
            r_mode_q  <= MODE_OFF;
            r_mod_bit <= 1'b1;
            r_din     <= 1'b0;
            r_rcnt    <= '0;
            r_pcnt    <= '0;
        end else begin
            if (w_frame_stb) begin
                r_mode_q <= mod_mode;
            end
            // Field shutdown overrides everything, including a coincident bit strobe.
            if (!field_en || (r_mode_q == MODE_OFF)) begin
                r_state   <= ST_OFF;
                r_mod_bit <= 1'b1;
                r_din     <= 1'b0;
                r_rcnt    <= '0;
                r_pcnt    <= '0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        r_state   <= ST_RAMP;
                        r_rcnt    <= '0;
                        r_mod_bit <= 1'b1;
                    end
                    ST_RAMP: begin
                        r_mod_bit <= 1'b1;
                        if (w_bit_stb) begin
                            if (r_rcnt == C_RAMP_LAST) begin
                                r_state <= ST_ACTIVE;
                            end else begin
                                r_rcnt <= r_rcnt + C_RW'(1);
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_bit_stb) begin
                            if (ssp_dout) begin
                                r_pcnt    <= '0;
                                r_mod_bit <= 1'b1;
                            end else if (r_pcnt == C_PAUSE_MAX) begin
                                // Pause too long: keep the tag powered and flag it.
                                r_mod_bit <= 1'b1;
                                r_din     <= 1'b1;
                            end else begin
                                r_pcnt    <= r_pcnt + C_PW'(1);
                                r_mod_bit <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= ST_OFF;
                endcase
            end
        end
    end

    assign w_carrier_on = (r_state != ST_OFF);

    assign pwr_hi  = ck_1356megb & w_carrier_on & ((r_mode_q == MODE_OOK) ? r_mod_bit : 1'b1);
    assign pwr_oe4 = w_carrier_on & (r_mode_q == MODE_SHALLOW) & ~r_mod_bit;
    assign pwr_lo  = 1'b0;
    assign pwr_oe1 = 1'b0;
    assign pwr_oe2 = 1'b0;
    assign pwr_oe3 = 1'b0;
    assign ssp_din = r_din;
    assign dbg     = ssp_frame;

endmodule

`default_nettype wire

// File: tb/tb_hi_reader_tx_param.sv
//==============================================================================
// Module      : tb_hi_reader_tx_param
// Description : Directed bench for hi_reader_tx_param (DIV 7, FRAME 8, RAMP 4, PAUSE 4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hi_reader_tx_param;

    logic       clk;
    logic       reset;
    logic       field_en;
    logic [1:0] mod_mode;
    logic       ssp_dout;
    logic       ssp_clk, ssp_frame, ssp_din, pwr_hi, pwr_lo;
    logic       pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    hi_reader_tx_param #(
        .SSP_DIV_LOG2   (7),
        .FRAME_BITS     (8),
        .RAMP_BITS      (4),
        .MAX_PAUSE_BITS (4)
    ) dut (
        .ck_1356meg  (clk),
        .reset       (reset),
        .ck_1356megb (~clk),
        .field_en    (field_en),
        .mod_mode    (mod_mode),
        .ssp_dout    (ssp_dout),
        .ssp_clk     (ssp_clk),
        .ssp_frame   (ssp_frame),
        .ssp_din     (ssp_din),
        .pwr_hi      (pwr_hi),
        .pwr_lo      (pwr_lo),
        .pwr_oe1     (pwr_oe1),
        .pwr_oe2     (pwr_oe2),
        .pwr_oe3     (pwr_oe3),
        .pwr_oe4     (pwr_oe4),
        .dbg         (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample point is 6 units after posedge: clk low, so the inverted carrier is high.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #6;
        cyc += n;
    endtask

    task automatic goto_cyc(input int target);
        if (target > cyc) adv(target - cyc);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // pwr_hi must drop while the carrier phase is low.
    task automatic chk_hi_phase();
        #5;
        chk("pwr_hi_low_phase", pwr_hi, 1'b0);
        #5;
        cyc += 1;
    endtask

    initial begin
        int n_frame, n_clk, n_rise, n_hi, n_oe4, n_hilow;
        logic prev_clk;

        reset    = 1'b1;
        field_en = 1'b0;
        mod_mode = 2'b11;
        ssp_dout = 1'b1;
        repeat (3) @(posedge clk);
        #6;
        reset = 1'b0;
        cyc   = 0;

        // Reset state
        chk("rst_ssp_clk", ssp_clk, 1'b0);
        chk("rst_ssp_frame", ssp_frame, 1'b1);
        chk("rst_dbg", dbg, 1'b1);
        chk("rst_ssp_din", ssp_din, 1'b0);
        chk("rst_pwr_hi", pwr_hi, 1'b0);
        chk("rst_pwr_oe4", pwr_oe4, 1'b0);
        chk("rst_tied", pwr_lo | pwr_oe1 | pwr_oe2 | pwr_oe3, 1'b0);

        // One full frame with the field off
        n_frame = 0; n_clk = 0; n_rise = 0; n_hi = 0;
        prev_clk = ssp_clk;
        for (int i = 0; i < 1024; i++) begin
            if (ssp_frame) n_frame++;
            if (ssp_clk) n_clk++;
            if (ssp_clk && !prev_clk) n_rise++;
            if (pwr_hi) n_hi++;
            prev_clk = ssp_clk;
            if (cyc == 64)  chk("clk_high_64", ssp_clk, 1'b1);
            if (cyc == 128) chk("frame_low_128", ssp_frame, 1'b0);
            adv(1);
        end
        chk_int("frame_high_count", n_frame, 128);
        chk_int("ssp_clk_high_count", n_clk, 512);
        chk_int("ssp_clk_rises", n_rise, 8);
        chk_int("pwr_hi_off_count", n_hi, 0);
        chk("frame_restart_1024", ssp_frame, 1'b1);

        // Field on in OOK: latch at frame start, 4-bit ramp ignoring dout
        mod_mode = 2'b00; field_en = 1'b1; ssp_dout = 1'b0;
        goto_cyc(1080); chk("pre_latch", pwr_hi, 1'b0);
        goto_cyc(1088); chk("latch_wait", pwr_hi, 1'b0);
        goto_cyc(1089); chk("ramp_on", pwr_hi, 1'b1);
        goto_cyc(1299); chk_hi_phase();
        chk("ramp_mid", pwr_hi, 1'b1);
        goto_cyc(1727); chk("ramp_end_carrier", pwr_hi, 1'b1);
        goto_cyc(1728); chk("first_sample_pause", pwr_hi, 1'b0);
        goto_cyc(1730); ssp_dout = 1'b1;
        goto_cyc(1855); chk("pause_hold", pwr_hi, 1'b0);
        goto_cyc(1856); chk("dout_one", pwr_hi, 1'b1);
        chk("din_clear", ssp_din, 1'b0);

        // Shallow mode, dout 1,0,1
        goto_cyc(1860); mod_mode = 2'b01;
        goto_cyc(2111); chk("shallow_pre_oe4", pwr_oe4, 1'b0);
        goto_cyc(2300);
        n_oe4 = 0; n_hilow = 0;
        for (int i = 0; i < 300; i++) begin
            if (cyc == 2300) ssp_dout = 1'b0;
            if (cyc == 2430) ssp_dout = 1'b1;
            if (pwr_oe4) n_oe4++;
            if (!pwr_hi) n_hilow++;
            adv(1);
        end
        chk_int("oe4_width", n_oe4, 128);
        chk_int("shallow_hi_gaps", n_hilow, 0);

        // OOK pause limiter: 6 zeros
        mod_mode = 2'b00;
        goto_cyc(3136); ssp_dout = 1'b0;
        goto_cyc(3140); chk("ook_back", pwr_hi, 1'b1);
        goto_cyc(3263); chk("lim_before", pwr_hi, 1'b1);
        goto_cyc(3264); chk("lim_pause1", pwr_hi, 1'b0);
        goto_cyc(3700); chk("lim_pause4", pwr_hi, 1'b0);
        chk("lim_din_pre", ssp_din, 1'b0);
        goto_cyc(3775); chk("lim_pause4_end", pwr_hi, 1'b0);
        goto_cyc(3776); chk("lim_forced5", pwr_hi, 1'b1);
        chk("lim_din_set", ssp_din, 1'b1);
        goto_cyc(3904); chk("lim_forced6", pwr_hi, 1'b1);
        goto_cyc(3950); ssp_dout = 1'b1;
        goto_cyc(4100); chk("lim_din_sticky", ssp_din, 1'b1);
        chk("lim_release", pwr_hi, 1'b1);

        // Mid-frame mode change at bit 3
        goto_cyc(4490); mod_mode = 2'b01; ssp_dout = 1'b0;
        goto_cyc(4544); chk("midframe_still_ook", pwr_hi, 1'b0);
        chk("midframe_no_oe4", pwr_oe4, 1'b0);
        goto_cyc(4600); ssp_dout = 1'b1;
        goto_cyc(5120); chk("next_frame", ssp_frame, 1'b1);
        goto_cyc(5150); ssp_dout = 1'b0;
        goto_cyc(5183); chk("pre_switch_oe4", pwr_oe4, 1'b0);
        goto_cyc(5184); chk("switched_hi", pwr_hi, 1'b1);
        chk("switched_oe4", pwr_oe4, 1'b1);

        // Reset pulse during a pause
        goto_cyc(5199); chk("din_before_reset", ssp_din, 1'b1);
        reset = 1'b1;
        adv(1);
        chk("rst_pulse_hi", pwr_hi, 1'b0);
        chk("rst_pulse_oe4", pwr_oe4, 1'b0);
        chk("rst_pulse_din", ssp_din, 1'b0);
        chk("rst_pulse_clk", ssp_clk, 1'b0);
        chk("rst_pulse_frame", ssp_frame, 1'b1);
        reset = 1'b0;
        cyc = 0;
        goto_cyc(64);  chk("rr_latch_wait", pwr_hi, 1'b0);
        goto_cyc(65);  chk("rr_ramp_hi", pwr_hi, 1'b1);
        chk("rr_ramp_oe4", pwr_oe4, 1'b0);
        goto_cyc(703); chk("rr_ramp_end", pwr_oe4, 1'b0);
        goto_cyc(704); chk("rr_active", pwr_oe4, 1'b1);

        // Build to a limiter trip, then drop field_en on a bit strobe
        goto_cyc(1215); chk("fe_din_pre", ssp_din, 1'b0);
        goto_cyc(1216); chk("fe_din_set", ssp_din, 1'b1);
        chk("fe_forced_oe4", pwr_oe4, 1'b0);
        goto_cyc(1343); chk("fe_carrier", pwr_hi, 1'b1);
        field_en = 1'b0;
        goto_cyc(1344); chk("fe_off_hi", pwr_hi, 1'b0);
        chk("fe_off_oe4", pwr_oe4, 1'b0);
        chk("fe_off_din", ssp_din, 1'b0);
        goto_cyc(1400); chk("fe_still_off", pwr_hi, 1'b0);
        field_en = 1'b1;
        goto_cyc(1401); chk("fe_reramp_hi", pwr_hi, 1'b1);
        chk("fe_reramp_oe4", pwr_oe4, 1'b0);
        goto_cyc(1983); chk("fe_reramp_end", pwr_oe4, 1'b0);
        goto_cyc(1984); chk("fe_reactive", pwr_oe4, 1'b1);
        chk("fe_reactive_din", ssp_din, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
